// File: rtl/iter_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// result written back to the register file through a registered one-cycle write port.
module iter_divider #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM_BIT = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [DATA_WIDTH-1:0]  src_a,
    input  logic [DATA_WIDTH-1:0]  src_b,
    input  logic [REG_NUM_BIT-1:0] rd,
    input  logic                   flush,
    output logic                   busy,
    output logic                   wen,
    output logic [REG_NUM_BIT-1:0] waddr,
    output logic [DATA_WIDTH-1:0]  wdata
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  quot_q, quot_d;
    logic [DATA_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0]  div_q, div_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   is_rem_q, is_rem_d;
    logic [REG_NUM_BIT-1:0] rd_q, rd_d;
    logic                   wen_q, wen_d;
    logic [REG_NUM_BIT-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    logic                   is_signed;
    logic [DATA_WIDTH-1:0]  abs_a, abs_b;
    logic [DATA_WIDTH:0]    trial;

    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);
    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_d      = div_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        rd_d       = rd_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        is_signed = !op[0];
        abs_a     = (is_signed && src_a[DATA_WIDTH-1]) ? (~src_a + 1'b1) : src_a;
        abs_b     = (is_signed && src_b[DATA_WIDTH-1]) ? (~src_b + 1'b1) : src_b;
        // Trial subtract of the divisor from the remainder shifted left by the next dividend bit
        trial     = {rem_q, quot_q[DATA_WIDTH-1]} - {1'b0, div_q};

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready && !flush) begin
                    rd_d     = rd;
                    is_rem_d = op[1];
                    if (src_b == '0) begin
                        quot_d     = '1;
                        rem_d      = src_a;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = DONE;
                    end else if (is_signed && src_a == MOST_NEG && src_b == '1) begin
                        quot_d     = src_a;
                        rem_d      = '0;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = DONE;
                    end else begin
                        quot_d     = abs_a;
                        rem_d      = '0;
                        div_d      = abs_b;
                        neg_quot_d = is_signed && (src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1]);
                        neg_rem_d  = is_signed && src_a[DATA_WIDTH-1];
                        cnt_d      = CNT_LOAD;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (!trial[DATA_WIDTH]) begin
                        rem_d  = trial[DATA_WIDTH-1:0];
                        quot_d = {quot_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = {rem_q[DATA_WIDTH-2:0], quot_q[DATA_WIDTH-1]};
                        quot_d = {quot_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                wen_d   = (rd_q != '0);
                waddr_d = rd_q;
                if (is_rem_q) begin
                    wdata_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                end else begin
                    wdata_d = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            is_rem_q   <= is_rem_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: table of directed divide/remainder vectors
// plus hand-written flush and reset sequences.
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    iter_divider #(.DATA_WIDTH(32), .REG_NUM_BIT(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b), .rd(rd), .flush(flush), .busy(busy),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        int          nwen;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one request for a single edge.
    task automatic accept(input logic [1:0] op_i, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd_i);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end
        op = op_i; src_a = a; src_b = b; rd = rd_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'bxx; src_a = 'x; src_b = 'x; rd = 'x;
    endtask

    task automatic watch(input int n, output int nwen, output int lat,
                         output logic [31:0] data, output logic [4:0] addr);
        nwen = 0; lat = -1; data = '0; addr = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (wen === 1'b1) begin
                nwen++;
                if (lat < 0) begin
                    lat = k; data = wdata; addr = waddr;
                end
            end
        end
    endtask

    initial begin
        int nw, lt;
        logic [31:0] d;
        logic [4:0] ad;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        5'd5,  32'd14,       33, 1};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,        5'd5,  32'd2,        33, 1};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        5'd10, 32'hFFFF_FFFD, 33, 1};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        5'd10, 32'hFFFF_FFFF, 33, 1};
        vecs[4]  = '{OP_DIVU, 32'h1234,       32'd0,        5'd3,  32'hFFFF_FFFF, 1,  1};
        vecs[5]  = '{OP_REMU, 32'h1234,       32'd0,        5'd3,  32'h1234,      1,  1};
        vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 1};
        vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0,        1,  1};
        vecs[8]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 5'd3,  32'hFFFF_FFFD, 33, 1};
        vecs[9]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE, 5'd3,  32'd1,        33, 1};
        vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        5'd31, 32'hFFFF_FFFF, 33, 1};
        vecs[11] = '{OP_DIV,  32'h8000_0000,  32'd0,        5'd2,  32'hFFFF_FFFF, 1,  1};
        vecs[12] = '{OP_REM,  32'h8000_0000,  32'd0,        5'd2,  32'h8000_0000, 1,  1};
        vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h0,        33, 1};
        vecs[14] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 33, 1};
        vecs[15] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd4,  32'd14,       33, 1};
        vecs[16] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 5'd4,  32'hFFFF_FFFE, 33, 1};
        vecs[17] = '{OP_DIVU, 32'd50,         32'd5,        5'd0,  32'd10,       33, 0};

        // Reset with in_valid high: nothing may be accepted, all outputs zero.
        rst = 1'b1; in_valid = 1'b1; flush = 1'b0; op = OP_DIVU;
        src_a = 32'd100; src_b = 32'd7; rd = 5'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_wen",      {31'd0, wen},      32'd0);
        chk("rst_waddr",    {27'd0, waddr},    32'd0);
        chk("rst_wdata",    wdata,             32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 18; i++) begin
            accept(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            watch(40, nw, lt, d, ad);
            chk($sformatf("v%0d_nwen", i), nw, vecs[i].nwen);
            if (vecs[i].nwen == 1) begin
                chk($sformatf("v%0d_lat", i), lt, vecs[i].lat);
                chk($sformatf("v%0d_waddr", i), {27'd0, ad}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d_wdata", i), d, vecs[i].exp);
                chk($sformatf("v%0d_hold_waddr", i), {27'd0, waddr}, {27'd0, vecs[i].rd});
                chk($sformatf("v%0d_hold_wdata", i), wdata, vecs[i].exp);
            end
            chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
        end

        // Flush mid-CALC abandons the request, then a fresh one completes.
        accept(OP_DIVU, 32'd100, 32'd7, 5'd5);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_calc_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_calc_busy",     {31'd0, busy},     32'd0);
        watch(40, nw, lt, d, ad);
        chk("flush_calc_nwen", nw, 0);
        accept(OP_DIVU, 32'd9, 32'd3, 5'd1);
        watch(40, nw, lt, d, ad);
        chk("after_flush_nwen",  nw, 1);
        chk("after_flush_lat",   lt, 33);
        chk("after_flush_waddr", {27'd0, ad}, 32'd1);
        chk("after_flush_wdata", d, 32'd3);

        // Flush in IDLE blocks acceptance even with in_valid high.
        op = OP_DIVU; src_a = 32'd9; src_b = 32'd3; rd = 5'd6;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        watch(40, nw, lt, d, ad);
        chk("flush_idle_nwen", nw, 0);

        // Flush while in DONE does not suppress the write.
        accept(OP_DIVU, 32'h1234, 32'd0, 5'd7);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_wen",   {31'd0, wen},   32'd1);
        chk("flush_done_waddr", {27'd0, waddr}, 32'd7);
        chk("flush_done_wdata", wdata,          32'hFFFF_FFFF);

        // Reset mid-CALC clears outputs and discards the operation.
        accept(OP_DIVU, 32'd50, 32'd5, 5'd9);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_calc_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_calc_busy",  {31'd0, busy},  32'd0);
        chk("rst_calc_wen",   {31'd0, wen},   32'd0);
        chk("rst_calc_waddr", {27'd0, waddr}, 32'd0);
        chk("rst_calc_wdata", wdata,          32'd0);
        rst = 1'b0;
        watch(40, nw, lt, d, ad);
        chk("rst_calc_nwen", nw, 0);

        // Reset while in DONE: no write after the reset edge.
        accept(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_done_wen", {31'd0, wen}, 32'd0);
        watch(40, nw, lt, d, ad);
        chk("rst_done_nwen", nw, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
